// File: rtl/acc_responder.sv
// Accelerator command responder: accepts a SUM/INC/CLR command from the core,
// walks the data memory word by word through its own port, then pulses accdone.
module acc_responder #(
    parameter int AW       = 6,
    parameter int MAXWORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accbypassA,
    input  logic [31:0]   fullinstructionA,
    input  logic [31:0]   startaddrA,
    input  logic [31:0]   datasizeA,
    output logic          accdone,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int NW = $clog2(MAXWORDS + 1);

    localparam logic [5:0] OP_SUM = 6'h20;
    localparam logic [5:0] OP_INC = 6'h21;
    localparam logic [5:0] OP_CLR = 6'h22;

    typedef enum logic [2:0] {
        IDLE,
        SUM_RD,
        RESULT,
        INC_RD,
        INC_WR,
        CLR_WR,
        DONE,
        RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] base_reg,  base_next;
    logic [NW-1:0] n_reg,     n_next;
    logic [NW-1:0] i_reg,     i_next;
    logic [31:0]   acc_reg,   acc_next;
    logic [31:0]   data_reg,  data_next;

    logic [NW-1:0] size_sat;
    logic [NW-1:0] i_inc;
    logic [AW-1:0] word_addr;
    logic [AW-1:0] result_addr;

    // Oversized requests clamp to the memory size.
    assign size_sat    = (datasizeA > 32'(MAXWORDS)) ? NW'(MAXWORDS) : NW'(datasizeA);
    assign i_inc       = i_reg + NW'(1);
    assign word_addr   = base_reg + AW'(i_reg);
    assign result_addr = base_reg + AW'(n_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            n_reg     <= '0;
            i_reg     <= '0;
            acc_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            n_reg     <= n_next;
            i_reg     <= i_next;
            acc_reg   <= acc_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        n_next     = n_reg;
        i_next     = i_reg;
        acc_next   = acc_reg;
        data_next  = data_reg;
        accdone    = 1'b0;
        busy       = (state_reg != IDLE);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_reg)
            IDLE: begin
                if (!accbypassA) begin
                    base_next = startaddrA[AW+1:2];
                    n_next    = size_sat;
                    i_next    = '0;
                    acc_next  = '0;
                    case (fullinstructionA[5:0])
                        OP_SUM:  state_next = (size_sat == '0) ? RESULT : SUM_RD;
                        OP_INC:  state_next = (size_sat == '0) ? DONE : INC_RD;
                        OP_CLR:  state_next = (size_sat == '0) ? DONE : CLR_WR;
                        default: state_next = DONE;
                    endcase
                end
            end
            SUM_RD: begin
                mem_addr = word_addr;
                acc_next = acc_reg + mem_rdata;
                i_next   = i_inc;
                if (i_inc == n_reg) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                mem_we     = 1'b1;
                mem_addr   = result_addr;
                mem_wdata  = acc_reg;
                state_next = DONE;
            end
            INC_RD: begin
                mem_addr   = word_addr;
                data_next  = mem_rdata;
                state_next = INC_WR;
            end
            INC_WR: begin
                mem_we     = 1'b1;
                mem_addr   = word_addr;
                mem_wdata  = data_reg + 32'd1;
                i_next     = i_inc;
                state_next = (i_inc < n_reg) ? INC_RD : DONE;
            end
            CLR_WR: begin
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = '0;
                i_next    = i_inc;
                if (i_inc == n_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                accdone    = 1'b1;
                state_next = RELEASE;
            end
            RELEASE: begin
                // A command still held low must not fire again.
                if (accbypassA) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_acc_responder.sv
// Self-checking bench for acc_responder: memory model, write scoreboard and
// per-scenario latency/result checks.
module tb_acc_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        accbypassA;
    logic [31:0] fullinstructionA;
    logic [31:0] startaddrA;
    logic [31:0] datasizeA;
    logic        accdone;
    logic        busy;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic [5:0]  poke_a_q[$];
    logic [31:0] poke_d_q[$];
    logic [5:0]  exp_a_q[$];
    logic [31:0] exp_d_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int we_count    = 0;

    always #5 clk = ~clk;

    acc_responder #(.AW(6), .MAXWORDS(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .accbypassA       (accbypassA),
        .fullinstructionA (fullinstructionA),
        .startaddrA       (startaddrA),
        .datasizeA        (datasizeA),
        .accdone          (accdone),
        .busy             (busy),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    // Sole owner of the memory image: applies bench preloads, then DUT writes.
    always @(posedge clk) begin : mem_model
        logic        wr;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [5:0]  pa;
        logic [31:0] pd;
        wr = mem_we;
        wa = mem_addr;
        wd = mem_wdata;
        while (poke_a_q.size() > 0) begin
            pa = poke_a_q.pop_front();
            pd = poke_d_q.pop_front();
            mem[pa] = pd;
        end
        if (wr) begin
            #1;
            mem[wa] = wd;
        end
    end

    // Scoreboard: every write the DUT issues is popped against the expected list.
    always @(negedge clk) begin : write_monitor
        logic [5:0]  ea;
        logic [31:0] ed;
        if (mem_we) begin
            we_count++;
            vectors++;
            if (exp_a_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write got addr=%0d data=%h required no write", mem_addr, mem_wdata);
            end else begin
                ea = exp_a_q.pop_front();
                ed = exp_d_q.pop_front();
                if ({mem_addr, mem_wdata} !== {ea, ed}) begin
                    miscompares++;
                    $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                             mem_addr, mem_wdata, ea, ed);
                end else begin
                    $display("write addr=%0d data=%h", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        poke_a_q.push_back(a);
        poke_d_q.push_back(d);
    endtask

    task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
        exp_a_q.push_back(a);
        exp_d_q.push_back(d);
    endtask

    // Issues one command; cyc = cycle index (1 = cycle after acceptance edge)
    // in which accdone was seen, -1 on timeout; after = accdone one cycle later.
    task automatic run_cmd(input logic [31:0] instr, input logic [31:0] sa,
                           input logic [31:0] sz, output int cyc, output logic after);
        @(negedge clk);
        accbypassA       = 1'b0;
        fullinstructionA = instr;
        startaddrA       = sa;
        datasizeA        = sz;
        @(posedge clk);
        cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                accbypassA       = 1'b1;
                fullinstructionA = $urandom;
                datasizeA        = $urandom;
            end
            if (accdone === 1'b1) begin
                cyc = k;
                break;
            end
        end
        @(negedge clk);
        after = accdone;
        $display("cmd op=%h start=%h size=%0d accdone_cycle=%0d", instr[5:0], sa, sz, cyc);
    endtask

    task automatic test_reset;
        reset            = 1'b0;
        accbypassA       = 1'b1;
        fullinstructionA = '0;
        startaddrA       = '0;
        datasizeA        = '0;
        for (int k = 0; k < 64; k++) poke(6'(k), $urandom);
        repeat (3) @(negedge clk);
        vectors += 5;
        if (accdone !== 1'b0) begin miscompares++; $display("FAIL reset_accdone got %b required 0", accdone); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b required 0", busy); end
        if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got %b required 0", mem_we); end
        if (mem_addr !== 6'd0) begin miscompares++; $display("FAIL reset_mem_addr got %0d required 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_mem_wdata got %h required 0", mem_wdata); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b required 0", busy); end
    endtask

    task automatic test_sum;
        int   cyc;
        logic after;
        poke(6'd4, 32'd1); poke(6'd5, 32'd2); poke(6'd6, 32'd3);
        poke(6'd7, 32'hFFFF_FFFF); poke(6'd8, 32'h1234_5678);
        we_count = 0;
        expect_wr(6'd8, 32'd5);
        run_cmd(32'h20, 32'h10, 32'd4, cyc, after);
        vectors += 5;
        if (cyc !== 6) begin miscompares++; $display("FAIL sum_latency got %0d required 6", cyc); end
        if (after !== 1'b0) begin miscompares++; $display("FAIL sum_single_pulse got %b required 0", after); end
        if (mem[8] !== 32'd5) begin miscompares++; $display("FAIL sum_result got %h required 5", mem[8]); end
        if (we_count !== 1) begin miscompares++; $display("FAIL sum_write_count got %0d required 1", we_count); end
        if (exp_a_q.size() !== 0) begin miscompares++; $display("FAIL sum_missing_writes got %0d required 0", exp_a_q.size()); end
    endtask

    task automatic test_inc;
        int   cyc;
        logic after;
        poke(6'd10, 32'hFFFF_FFFF); poke(6'd11, 32'd7);
        we_count = 0;
        expect_wr(6'd10, 32'd0);
        expect_wr(6'd11, 32'd8);
        run_cmd(32'h21, 32'h28, 32'd2, cyc, after);
        vectors += 5;
        if (cyc !== 5) begin miscompares++; $display("FAIL inc_latency got %0d required 5", cyc); end
        if (mem[10] !== 32'd0) begin miscompares++; $display("FAIL inc_word10 got %h required 0", mem[10]); end
        if (mem[11] !== 32'd8) begin miscompares++; $display("FAIL inc_word11 got %h required 8", mem[11]); end
        if (we_count !== 2) begin miscompares++; $display("FAIL inc_we_cycles got %0d required 2", we_count); end
        if (exp_a_q.size() !== 0) begin miscompares++; $display("FAIL inc_missing_writes got %0d required 0", exp_a_q.size()); end
    endtask

    task automatic test_clr_wrap;
        int   cyc;
        logic after;
        poke(6'd62, 32'h11); poke(6'd63, 32'h22); poke(6'd0, 32'h33);
        poke(6'd1, 32'h44); poke(6'd2, 32'hA5A5_A5A5);
        we_count = 0;
        expect_wr(6'd62, 32'd0); expect_wr(6'd63, 32'd0);
        expect_wr(6'd0, 32'd0);  expect_wr(6'd1, 32'd0);
        run_cmd(32'h22, 32'hF8, 32'd4, cyc, after);
        vectors += 4;
        if (cyc !== 5) begin miscompares++; $display("FAIL clr_latency got %0d required 5", cyc); end
        if (mem[2] !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL clr_word2_untouched got %h required a5a5a5a5", mem[2]); end
        if (we_count !== 4) begin miscompares++; $display("FAIL clr_write_count got %0d required 4", we_count); end
        if (exp_a_q.size() !== 0) begin miscompares++; $display("FAIL clr_missing_writes got %0d required 0", exp_a_q.size()); end
    endtask

    task automatic test_size_corners;
        int   cyc;
        logic after;
        poke(6'd3, 32'hCAFE_F00D);
        we_count = 0;
        expect_wr(6'd3, 32'd0);
        run_cmd(32'h20, 32'h0C, 32'd0, cyc, after);
        vectors += 3;
        if (cyc !== 2) begin miscompares++; $display("FAIL sum0_latency got %0d required 2", cyc); end
        if (mem[3] !== 32'd0) begin miscompares++; $display("FAIL sum0_result got %h required 0", mem[3]); end
        if (we_count !== 1) begin miscompares++; $display("FAIL sum0_write_count got %0d required 1", we_count); end

        we_count = 0;
        run_cmd(32'h21, 32'h0C, 32'd0, cyc, after);
        vectors += 2;
        if (cyc !== 1) begin miscompares++; $display("FAIL inc0_latency got %0d required 1", cyc); end
        if (we_count !== 0) begin miscompares++; $display("FAIL inc0_write_count got %0d required 0", we_count); end

        we_count = 0;
        run_cmd(32'h3F, 32'h40, 32'd5, cyc, after);
        vectors += 2;
        if (cyc !== 1) begin miscompares++; $display("FAIL badop_latency got %0d required 1", cyc); end
        if (we_count !== 0) begin miscompares++; $display("FAIL badop_write_count got %0d required 0", we_count); end
    endtask

    task automatic test_saturate;
        int   cyc;
        logic after;
        we_count = 0;
        for (int k = 0; k < 64; k++) expect_wr(6'(k), 32'd0);
        run_cmd(32'h22, 32'h0, 32'd1000, cyc, after);
        vectors += 3;
        if (cyc !== 65) begin miscompares++; $display("FAIL sat_latency got %0d required 65", cyc); end
        if (we_count !== 64) begin miscompares++; $display("FAIL sat_write_count got %0d required 64", we_count); end
        if (exp_a_q.size() !== 0) begin miscompares++; $display("FAIL sat_missing_writes got %0d required 0", exp_a_q.size()); end
    endtask

    task automatic test_hold_no_retrigger;
        int   cyc;
        int   dones;
        logic after;
        poke(6'd40, 32'h1);
        we_count = 0;
        expect_wr(6'd40, 32'd0);
        @(negedge clk);
        accbypassA       = 1'b0;
        fullinstructionA = 32'h22;
        startaddrA       = 32'hA0;
        datasizeA        = 32'd1;
        @(posedge clk);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (accdone === 1'b1) dones++;
        end
        vectors += 3;
        if (dones !== 1) begin miscompares++; $display("FAIL hold_accdone_count got %0d required 1", dones); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy got %b required 1", busy); end
        if (we_count !== 1) begin miscompares++; $display("FAIL hold_write_count got %0d required 1", we_count); end
        accbypassA = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL release_busy got %b required 0", busy); end
        run_cmd(32'h3F, 32'h0, 32'd0, cyc, after);
        vectors++;
        if (cyc !== 1) begin miscompares++; $display("FAIL rearm_latency got %0d required 1", cyc); end
    endtask

    task automatic test_reset_mid_inc;
        int dones;
        for (int k = 0; k < 8; k++) poke(6'(20 + k), 32'(100 + k));
        we_count = 0;
        expect_wr(6'd20, 32'd101);
        expect_wr(6'd21, 32'd102);
        @(negedge clk);
        accbypassA       = 1'b0;
        fullinstructionA = 32'h21;
        startaddrA       = 32'h50;
        datasizeA        = 32'd8;
        @(posedge clk);
        @(negedge clk);
        accbypassA = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        vectors += 5;
        if (accdone !== 1'b0) begin miscompares++; $display("FAIL midrst_accdone got %b required 0", accdone); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b required 0", busy); end
        if (mem_we !== 1'b0) begin miscompares++; $display("FAIL midrst_mem_we got %b required 0", mem_we); end
        if (mem_addr !== 6'd0) begin miscompares++; $display("FAIL midrst_mem_addr got %0d required 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin miscompares++; $display("FAIL midrst_mem_wdata got %h required 0", mem_wdata); end
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (accdone === 1'b1) dones++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (accdone === 1'b1) dones++;
        end
        vectors += 3;
        if (dones !== 0) begin miscompares++; $display("FAIL midrst_accdone_count got %0d required 0", dones); end
        if (we_count !== 2) begin miscompares++; $display("FAIL midrst_write_count got %0d required 2", we_count); end
        if (exp_a_q.size() !== 0) begin miscompares++; $display("FAIL midrst_missing_writes got %0d required 0", exp_a_q.size()); end
        for (int k = 0; k < 8; k++) begin
            logic [31:0] want;
            want = (k < 2) ? 32'(101 + k) : 32'(100 + k);
            vectors++;
            if (mem[20 + k] !== want) begin
                miscompares++;
                $display("FAIL midrst_word%0d got %h required %h", 20 + k, mem[20 + k], want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_inc();
        test_clr_wrap();
        test_size_corners();
        test_saturate();
        test_hold_no_retrigger();
        test_reset_mid_inc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
